// File: rtl/reg_file_2r1w_pkg.sv
// Shared definitions for the DaVinci GPR file.
// Contents:
//   REG_DATA_WIDTH  - register/data width (32)
//   REG_INDEX_WIDTH - register index width (5)
//   NUM_OF_REG      - number of architectural registers (32)
//   REG_ZERO        - index of the hard-wired zero register
//   decode_write    - write-enable decoder, one bit per writable register
//   fwd_hit         - same-cycle write-to-read forwarding match
package reg_file_2r1w_pkg;

    localparam int REG_DATA_WIDTH  = 32;
    localparam int REG_INDEX_WIDTH = 5;
    localparam int NUM_OF_REG      = 32;
    localparam logic [REG_INDEX_WIDTH-1:0] REG_ZERO = 5'd0;

    // Bit 0 is deliberately absent: R0 has no write enable at all.
    // A write to index 0 therefore produces an all-zero vector and is dropped.
    function automatic logic [NUM_OF_REG-1:1] decode_write(
        input logic                       wr_en,
        input logic [REG_INDEX_WIDTH-1:0] idx
    );
        logic [NUM_OF_REG-1:1] oh;
        for (int j = 1; j < NUM_OF_REG; j++) begin
            if (wr_en && (idx == j[REG_INDEX_WIDTH-1:0])) begin
                oh[j] = 1'b1;
            end else begin
                oh[j] = 1'b0;
            end
        end
        return oh;
    endfunction

    // True when the write in flight this edge targets the register being read.
    // Index 0 never matches, so R0 can never be forwarded a non-zero value.
    function automatic logic fwd_hit(
        input logic                       wr_en,
        input logic [REG_INDEX_WIDTH-1:0] wr_idx,
        input logic [REG_INDEX_WIDTH-1:0] rd_idx
    );
        return wr_en && (wr_idx == rd_idx) && (rd_idx != REG_ZERO);
    endfunction

endpackage

// File: rtl/reg_file_2r1w_reg32_ld.sv
// reg32_ld: D-register with load enable and asynchronous active-low clear.
// Ports:
//   clk   - clock, rising edge
//   rst_n - asynchronous active-low clear (q -> 0)
//   load  - when 1 at the rising edge, q takes d; otherwise q holds
//   d     - data in
//   q     - registered data out
module reg32_ld #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] q_r;

    // Storage element: clear on reset, load on enable, otherwise hold.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_r <= {WIDTH{1'b0}};
        end else if (load) begin
            q_r <= d;
        end else begin
            q_r <= q_r;
        end
    end

    assign q = q_r;

endmodule

// File: rtl/reg_file_2r1w.sv
// reg_file_2r1w: 32x32-bit GPR file for the DaVinci datapath, two read ports
// and one write port. R0 always reads zero; a write and a read of the same
// index on the same edge returns the newly written value.
// Ports:
//   CLK      - clock, all state on rising edge
//   RST      - asynchronous active-low reset (clears GPRs and outputs)
//   READ     - capture both read ports on this edge
//   WRITE    - commit DATA_W to ADDR_W on this edge
//   ADDR_R1  - read port 1 register index
//   ADDR_R2  - read port 2 register index
//   ADDR_W   - write register index
//   DATA_W   - write data
//   DATA_R1  - read port 1 data (registered, holds when READ=0)
//   DATA_R2  - read port 2 data (registered, holds when READ=0)
//   VALID_R  - one-cycle pulse: DATA_R1/DATA_R2 were updated on the last edge
module reg_file_2r1w
    import reg_file_2r1w_pkg::*;
#(
    parameter int DATA_WIDTH = REG_DATA_WIDTH,
    parameter int ADDR_WIDTH = REG_INDEX_WIDTH
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  READ,
    input  logic                  WRITE,
    input  logic [ADDR_WIDTH-1:0] ADDR_R1,
    input  logic [ADDR_WIDTH-1:0] ADDR_R2,
    input  logic [ADDR_WIDTH-1:0] ADDR_W,
    input  logic [DATA_WIDTH-1:0] DATA_W,
    output logic [DATA_WIDTH-1:0] DATA_R1,
    output logic [DATA_WIDTH-1:0] DATA_R2,
    output logic                  VALID_R
);

    logic [DATA_WIDTH-1:0] reg_q_s [NUM_OF_REG];
    logic [NUM_OF_REG-1:1] wr_onehot_s;

    logic [DATA_WIDTH-1:0] rd1_tree_s;
    logic [DATA_WIDTH-1:0] rd2_tree_s;
    logic [DATA_WIDTH-1:0] rd1_fwd_s;
    logic [DATA_WIDTH-1:0] rd2_fwd_s;
    logic [DATA_WIDTH-1:0] rd1_next_s;
    logic [DATA_WIDTH-1:0] rd2_next_s;
    logic                  valid_r;

    assign wr_onehot_s = decode_write(WRITE, ADDR_W);

    // GPR storage. R0 is a real register whose load is tied off, so it stays
    // at its reset value of zero forever.
    for (genvar i = 0; i < NUM_OF_REG; i++) begin : g_gpr
        if (i == 0) begin : g_r0
            reg32_ld #(.WIDTH(DATA_WIDTH)) u_reg (
                .clk   (CLK),
                .rst_n (RST),
                .load  (1'b0),
                .d     (DATA_W),
                .q     (reg_q_s[i])
            );
        end else begin : g_rn
            reg32_ld #(.WIDTH(DATA_WIDTH)) u_reg (
                .clk   (CLK),
                .rst_n (RST),
                .load  (wr_onehot_s[i]),
                .d     (DATA_W),
                .q     (reg_q_s[i])
            );
        end
    end

    // Read port 1: 32:1 select tree, forward mux, then zero-force for R0.
    always_comb begin
        rd1_tree_s = reg_q_s[ADDR_R1];
        if (fwd_hit(WRITE, ADDR_W, ADDR_R1)) begin
            rd1_fwd_s = DATA_W;
        end else begin
            rd1_fwd_s = rd1_tree_s;
        end
        if (ADDR_R1 == REG_ZERO) begin
            rd1_next_s = {DATA_WIDTH{1'b0}};
        end else begin
            rd1_next_s = rd1_fwd_s;
        end
    end

    // Read port 2: same structure as port 1.
    always_comb begin
        rd2_tree_s = reg_q_s[ADDR_R2];
        if (fwd_hit(WRITE, ADDR_W, ADDR_R2)) begin
            rd2_fwd_s = DATA_W;
        end else begin
            rd2_fwd_s = rd2_tree_s;
        end
        if (ADDR_R2 == REG_ZERO) begin
            rd2_next_s = {DATA_WIDTH{1'b0}};
        end else begin
            rd2_next_s = rd2_fwd_s;
        end
    end

    // Output data registers load only on READ so they hold between reads.
    reg32_ld #(.WIDTH(DATA_WIDTH)) u_out_r1 (
        .clk   (CLK),
        .rst_n (RST),
        .load  (READ),
        .d     (rd1_next_s),
        .q     (DATA_R1)
    );

    reg32_ld #(.WIDTH(DATA_WIDTH)) u_out_r2 (
        .clk   (CLK),
        .rst_n (RST),
        .load  (READ),
        .d     (rd2_next_s),
        .q     (DATA_R2)
    );

    // Valid pulse: registered copy of the read strobe.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            valid_r <= 1'b0;
        end else begin
            valid_r <= READ;
        end
    end

    assign VALID_R = valid_r;

endmodule

// File: tb/tb_reg_file_2r1w.sv
module tb_reg_file_2r1w;

    typedef struct {
        logic [31:0] d1;
        logic [31:0] d2;
    } exp_t;

    logic        CLK;
    logic        RST;
    logic        READ;
    logic        WRITE;
    logic [4:0]  ADDR_R1;
    logic [4:0]  ADDR_R2;
    logic [4:0]  ADDR_W;
    logic [31:0] DATA_W;
    logic [31:0] DATA_R1;
    logic [31:0] DATA_R2;
    logic        VALID_R;

    int total;
    int bad;

    logic [31:0] mdl [32];
    exp_t        sb_q [$];
    exp_t        got;

    reg_file_2r1w dut (
        .CLK     (CLK),
        .RST     (RST),
        .READ    (READ),
        .WRITE   (WRITE),
        .ADDR_R1 (ADDR_R1),
        .ADDR_R2 (ADDR_R2),
        .ADDR_W  (ADDR_W),
        .DATA_W  (DATA_W),
        .DATA_R1 (DATA_R1),
        .DATA_R2 (DATA_R2),
        .VALID_R (VALID_R)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    function automatic logic [31:0] model_read(input logic [4:0] a, input logic wr,
                                               input logic [4:0] aw, input logic [31:0] dw);
        if (a == 5'd0) return 32'h0;
        if (wr && (aw == a)) return dw;
        return mdl[a];
    endfunction

    // Drive one edge; expected read data is pushed to the scoreboard at drive time.
    task automatic drive_edge(input logic rd, input logic wr, input logic [4:0] a1,
                              input logic [4:0] a2, input logic [4:0] aw, input logic [31:0] dw);
        exp_t e;
        READ = rd; WRITE = wr; ADDR_R1 = a1; ADDR_R2 = a2; ADDR_W = aw; DATA_W = dw;
        if (rd) begin
            e.d1 = model_read(a1, wr, aw, dw);
            e.d2 = model_read(a2, wr, aw, dw);
            sb_q.push_back(e);
        end
        @(posedge CLK);
        #1;
        if (wr && (aw != 5'd0)) mdl[aw] = dw;
        READ = 1'b0; WRITE = 1'b0;
    endtask

    task automatic pop_exp(output exp_t e);
        if (sb_q.size() == 0) begin
            total++; bad++;
            $display("FAIL scoreboard_empty: actual=empty required=entry");
            e.d1 = 32'h0; e.d2 = 32'h0;
        end else begin
            e = sb_q.pop_front();
        end
    endtask

    task automatic test_reset();
        exp_t e;
        // Put known content into R3 and the output registers first.
        drive_edge(1'b0, 1'b1, 5'd0, 5'd0, 5'd3, 32'h1111_1111);
        drive_edge(1'b1, 1'b0, 5'd3, 5'd3, 5'd0, 32'h0);
        pop_exp(e);
        total++;
        if (DATA_R1 !== e.d1) begin bad++; $display("FAIL pre_reset_r3: actual=%h required=%h", DATA_R1, e.d1); end
        // Reset asserted asynchronously in the middle of a write.
        WRITE = 1'b1; ADDR_W = 5'd3; DATA_W = 32'hDEAD_BEEF; READ = 1'b1; ADDR_R1 = 5'd3;
        #2;
        RST = 1'b0;
        #1;
        total++;
        if (DATA_R1 !== 32'h0 || DATA_R2 !== 32'h0 || VALID_R !== 1'b0) begin
            bad++; $display("FAIL async_reset: actual=%h/%h/%b required=0/0/0", DATA_R1, DATA_R2, VALID_R);
        end
        @(posedge CLK);
        #1;
        total++;
        if (DATA_R1 !== 32'h0 || VALID_R !== 1'b0) begin
            bad++; $display("FAIL reset_hold: actual=%h/%b required=0/0", DATA_R1, VALID_R);
        end
        for (int i = 0; i < 32; i++) mdl[i] = 32'h0;
        READ = 1'b0; WRITE = 1'b0;
        RST = 1'b1;
        drive_edge(1'b1, 1'b0, 5'd3, 5'd3, 5'd0, 32'h0);
        pop_exp(e);
        total++;
        if (DATA_R1 !== 32'h0 || e.d1 !== 32'h0 || VALID_R !== 1'b1) begin
            bad++; $display("FAIL reset_discard_write: actual=%h/%b required=0/1", DATA_R1, VALID_R);
        end
    endtask

    task automatic test_write_read();
        exp_t e;
        drive_edge(1'b0, 1'b1, 5'd0, 5'd0, 5'd7, 32'h1234_5678);
        drive_edge(1'b1, 1'b0, 5'd7, 5'd7, 5'd0, 32'h0);
        pop_exp(e);
        total++;
        if (DATA_R1 !== e.d1 || DATA_R2 !== e.d2 || DATA_R1 !== 32'h1234_5678) begin
            bad++; $display("FAIL write_read: actual=%h/%h required=%h/%h", DATA_R1, DATA_R2, e.d1, e.d2);
        end
        total++;
        if (VALID_R !== 1'b1) begin bad++; $display("FAIL valid_rise: actual=%b required=1", VALID_R); end
        drive_edge(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 32'h0);
        total++;
        if (VALID_R !== 1'b0) begin bad++; $display("FAIL valid_width: actual=%b required=0", VALID_R); end
    endtask

    task automatic test_r0();
        exp_t e;
        drive_edge(1'b0, 1'b1, 5'd0, 5'd0, 5'd0, 32'hFFFF_FFFF);
        drive_edge(1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 32'h0);
        pop_exp(e);
        total++;
        if (DATA_R1 !== e.d1 || DATA_R2 !== 32'h0) begin
            bad++; $display("FAIL r0_write_dropped: actual=%h/%h required=0/0", DATA_R1, DATA_R2);
        end
        // Same-edge write and read of R0 must not forward.
        drive_edge(1'b1, 1'b1, 5'd0, 5'd7, 5'd0, 32'hFFFF_FFFF);
        pop_exp(e);
        total++;
        if (DATA_R1 !== e.d1 || DATA_R2 !== e.d2) begin
            bad++; $display("FAIL r0_no_forward: actual=%h/%h required=%h/%h", DATA_R1, DATA_R2, e.d1, e.d2);
        end
    endtask

    task automatic test_forward();
        exp_t e;
        drive_edge(1'b0, 1'b1, 5'd0, 5'd0, 5'd5, 32'h0000_000A);
        drive_edge(1'b1, 1'b1, 5'd5, 5'd5, 5'd5, 32'h0000_000B);
        pop_exp(e);
        total++;
        if (DATA_R1 !== e.d1 || DATA_R2 !== e.d2 || DATA_R1 !== 32'h0000_000B) begin
            bad++; $display("FAIL forward: actual=%h/%h required=%h/%h", DATA_R1, DATA_R2, e.d1, e.d2);
        end
        // Forward on one port only; the other reads stored R7.
        drive_edge(1'b1, 1'b1, 5'd7, 5'd5, 5'd5, 32'h0000_000C);
        pop_exp(e);
        total++;
        if (DATA_R1 !== e.d1 || DATA_R2 !== e.d2) begin
            bad++; $display("FAIL forward_one_port: actual=%h/%h required=%h/%h", DATA_R1, DATA_R2, e.d1, e.d2);
        end
    endtask

    task automatic test_hold();
        exp_t e;
        drive_edge(1'b1, 1'b0, 5'd7, 5'd5, 5'd0, 32'h0);
        pop_exp(e);
        total++;
        if (DATA_R1 !== 32'h1234_5678 || DATA_R2 !== e.d2) begin
            bad++; $display("FAIL hold_setup: actual=%h/%h required=12345678/%h", DATA_R1, DATA_R2, e.d2);
        end
        drive_edge(1'b0, 1'b1, 5'd7, 5'd7, 5'd7, 32'h0);
        total++;
        if (DATA_R1 !== 32'h1234_5678 || DATA_R2 !== e.d2 || VALID_R !== 1'b0) begin
            bad++; $display("FAIL hold: actual=%h/%h/%b required=12345678/%h/0", DATA_R1, DATA_R2, VALID_R, e.d2);
        end
        drive_edge(1'b1, 1'b0, 5'd7, 5'd7, 5'd0, 32'h0);
        pop_exp(e);
        total++;
        if (DATA_R1 !== e.d1 || DATA_R1 !== 32'h0) begin
            bad++; $display("FAIL hold_write_landed: actual=%h required=%h", DATA_R1, e.d1);
        end
    endtask

    task automatic test_sweep();
        exp_t e;
        for (int i = 1; i < 32; i++) begin
            drive_edge(1'b0, 1'b1, 5'd0, 5'd0, 5'(i), 32'(i) * 32'h0101_0101);
        end
        for (int i = 0; i < 32; i++) begin
            drive_edge(1'b1, 1'b0, 5'(i), 5'(31 - i), 5'd0, 32'h0);
            pop_exp(e);
            total++;
            if (DATA_R1 !== e.d1 || DATA_R2 !== e.d2 || VALID_R !== 1'b1) begin
                bad++;
                $display("FAIL sweep_%0d: actual=%h/%h/%b required=%h/%h/1", i, DATA_R1, DATA_R2, VALID_R, e.d1, e.d2);
            end
        end
    endtask

    task automatic test_back_to_back();
        exp_t e;
        // Random mix of reads and writes, read every edge.
        for (int k = 0; k < 40; k++) begin
            drive_edge(1'b1, 1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)),
                       5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)), $urandom);
            pop_exp(e);
            total++;
            if (DATA_R1 !== e.d1 || DATA_R2 !== e.d2) begin
                bad++; $display("FAIL back_to_back_%0d: actual=%h/%h required=%h/%h", k, DATA_R1, DATA_R2, e.d1, e.d2);
            end
        end
    endtask

    initial begin
        total = 0; bad = 0;
        for (int i = 0; i < 32; i++) mdl[i] = 32'h0;
        RST = 1'b0; READ = 1'b0; WRITE = 1'b0;
        ADDR_R1 = 5'd0; ADDR_R2 = 5'd0; ADDR_W = 5'd0; DATA_W = 32'h0;
        #1;
        total++;
        if (DATA_R1 !== 32'h0 || DATA_R2 !== 32'h0 || VALID_R !== 1'b0) begin
            bad++; $display("FAIL initial_reset: actual=%h/%h/%b required=0/0/0", DATA_R1, DATA_R2, VALID_R);
        end
        repeat (2) @(posedge CLK);
        #1;
        RST = 1'b1;
        test_reset();
        test_write_read();
        test_r0();
        test_forward();
        test_hold();
        test_sweep();
        test_back_to_back();
        total++;
        if (sb_q.size() != 0) begin
            bad++; $display("FAIL scoreboard_drain: actual=%0d required=0", sb_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
